// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the SAP-1 operand/result stage.
//   WIDTH_DEF : default datapath width of A, B, the W-bus and the adder operands
//   state_t   : sequencing states for one ADD/SUB operation
package alu_operand_stage_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/load_register.sv
// Parallel-load register with synchronous clear.
//   clk  : rising-edge clock
//   rst  : synchronous active-high clear (q <= 0)
//   load : capture d at the next edge
//   d    : data in
//   q    : registered data out
module load_register
  import alu_operand_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand and result stage in front of the external 4-bit adder-subtracter.
// Holds accumulator A and operand B, presents them with the latched op to the
// adder, and writes the adder's sum back into A with carry/zero flags.
//   clk, rst             : clock, synchronous active-high reset
//   bus_in               : W-bus value (source for A loads and B capture)
//   la                   : load A from bus_in (honoured in IDLE only)
//   ea                   : drive A onto the bus (honoured in every state)
//   start, op_sub        : begin ADD (op_sub=0) or SUB (op_sub=1); B captured from bus_in
//   alu_sum, alu_carry   : results returned by the adder-subtracter
//   alu_a, alu_b, alu_sub: operands and op presented to the adder-subtracter
//   bus_out, bus_drive   : A value and its bus enable (tri-state lives at top level)
//   carry_flag, zero_flag: flags latched at writeback
//   busy, done           : busy in SETTLE/WRITE/DONE, done pulses for one cycle in DONE
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             la,
  input  logic             ea,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_carry,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sub,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_drive,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic             op_q;
  logic             carry_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;
  logic             idle;
  logic             a_load;
  logic             b_load;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == '0);
  endfunction

  assign idle   = (state == ST_IDLE);
  // start wins over la in the same IDLE cycle; both are ignored while busy.
  assign b_load = idle && start;
  assign a_load = (idle && !start && la) || (state == ST_WRITE);
  assign a_d    = (state == ST_WRITE) ? alu_sum : bus_in;

  load_register #(.WIDTH(WIDTH)) u_reg_a (
    .clk  (clk),
    .rst  (rst),
    .load (a_load),
    .d    (a_d),
    .q    (a_q)
  );

  load_register #(.WIDTH(WIDTH)) u_reg_b (
    .clk  (clk),
    .rst  (rst),
    .load (b_load),
    .d    (bus_in),
    .q    (b_q)
  );

  // Sequencer: busy/done are registered alongside the state so they change
  // exactly on the state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op_sub;
            busy_q <= 1'b1;
            state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          carry_q <= alu_carry;
          zero_q  <= is_zero(alu_sum);
          done_q  <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sub    = op_q;
  assign bus_out    = a_q;
  assign bus_drive  = ea;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] bus_in = '0;
  logic         la = 1'b0;
  logic         ea = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] alu_sum;
  logic         alu_carry;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_sub;
  logic [W-1:0] bus_out;
  logic         bus_drive;
  logic         carry_flag;
  logic         zero_flag;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int ma = 0, mb = 0, mc = 0, mz = 0;

  always #5 clk = ~clk;

  // Stand-in for adder_subtracter_4Bit: A + B, or A + ~B + 1 for SUB.
  always_comb begin
    int a, b, r;
    a = int'(alu_a);
    b = int'(alu_b);
    if (alu_sub) r = a + ((~b) & (M - 1)) + 1;
    else         r = a + b;
    alu_sum   = W'(r % M);
    alu_carry = (r >= M);
  end

  alu_operand_stage #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_in     (bus_in),
    .la         (la),
    .ea         (ea),
    .start      (start),
    .op_sub     (op_sub),
    .alu_sum    (alu_sum),
    .alu_carry  (alu_carry),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sub    (alu_sub),
    .bus_out    (bus_out),
    .bus_drive  (bus_drive),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Arithmetic from the operation definition: modulo 2^W result,
  // carry = unsigned overflow for ADD, carry = no-borrow for SUB.
  task automatic model_exec(input bit sub);
    int r;
    if (sub) begin
      r  = ma - mb;
      mc = (ma >= mb) ? 1 : 0;
    end else begin
      r  = ma + mb;
      mc = (r >= M) ? 1 : 0;
    end
    ma = ((r % M) + M) % M;
    mz = (ma == 0) ? 1 : 0;
  endtask

  task automatic load_a(input int v);
    bus_in = W'(v); la = 1'b1;
    tick();
    la = 1'b0;
    ma = v;
    chk("la_load", alu_a, ma);
    chk("la_flags_c", carry_flag, mc);
    chk("la_flags_z", zero_flag, mz);
  endtask

  task automatic do_op(input int b, input bit sub, input bit with_la, input bit noise);
    int old_a, old_c, old_z, dn;
    bus_in = W'(b); op_sub = sub; start = 1'b1; la = with_la;
    tick();                                  // SETTLE
    start = 1'b0; la = 1'b0;
    old_a = ma; old_c = mc; old_z = mz;
    mb = b;
    model_exec(sub);
    dn = int'(done);
    chk("settle_busy", busy, 1);
    chk("settle_b", alu_b, mb);
    chk("settle_sub", alu_sub, sub);
    chk("settle_a_hold", alu_a, old_a);
    chk("settle_bus_out", bus_out, old_a);
    chk("settle_bus_drive", bus_drive, ea);
    chk("settle_carry_hold", carry_flag, old_c);
    if (noise) begin
      start = 1'b1; la = 1'b1; op_sub = ~sub; bus_in = ~W'(b);
    end
    tick();                                  // WRITE
    dn += int'(done);
    chk("write_busy", busy, 1);
    chk("write_a_hold", alu_a, old_a);
    chk("write_b_hold", alu_b, mb);
    chk("write_zero_hold", zero_flag, old_z);
    chk("write_bus_drive", bus_drive, ea);
    tick();                                  // DONE
    dn += int'(done);
    chk("done_busy", busy, 1);
    chk("done_pulse", done, 1);
    chk("done_a", alu_a, ma);
    chk("done_bus_out", bus_out, ma);
    chk("done_carry", carry_flag, mc);
    chk("done_zero", zero_flag, mz);
    chk("done_bus_drive", bus_drive, ea);
    tick();                                  // IDLE
    start = 1'b0; la = 1'b0;
    dn += int'(done);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("done_count", dn, 1);
    chk("idle_a", alu_a, ma);
    chk("idle_b", alu_b, mb);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_sub", alu_sub, 0);
    chk("rst_carry", carry_flag, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // ADD 5 + 3
    load_a(5);
    do_op(3, 1'b0, 1'b0, 1'b0);
    chk("add_a8", alu_a, 8);

    // ADD wrap 9 + 7 -> 0, carry, zero
    load_a(9);
    do_op(7, 1'b0, 1'b0, 1'b0);
    chk("wrap_a0", alu_a, 0);
    chk("wrap_c1", carry_flag, 1);
    chk("wrap_z1", zero_flag, 1);

    // Reset during WRITE: op abandoned, everything cleared, no done
    load_a(10);
    bus_in = 4'd2; op_sub = 1'b0; start = 1'b1;
    tick();                                  // SETTLE
    start = 1'b0;
    tick();                                  // WRITE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ma = 0; mb = 0; mc = 0; mz = 0;
    chk("rstmid_a", alu_a, 0);
    chk("rstmid_b", alu_b, 0);
    chk("rstmid_carry", carry_flag, 0);
    chk("rstmid_zero", zero_flag, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    tick();
    chk("rstmid_done_after", done, 0);
    chk("rstmid_a_after", alu_a, 0);

    // SUB 5 - 3 and 3 - 5, with ea held high to watch bus_out
    ea = 1'b1;
    load_a(5);
    do_op(3, 1'b1, 1'b0, 1'b0);
    chk("sub_a2", alu_a, 2);
    chk("sub_c1", carry_flag, 1);
    load_a(3);
    do_op(5, 1'b1, 1'b0, 1'b0);
    chk("sub_aE", alu_a, 14);
    chk("sub_c0", carry_flag, 0);
    chk("sub_z0", zero_flag, 0);

    // start and la together: start wins, A not loaded from bus
    load_a(4);
    do_op(6, 1'b0, 1'b1, 1'b0);
    chk("prio_b6", alu_b, 6);
    chk("prio_a10", alu_a, 10);

    // start/la pulsed while busy: ignored
    load_a(7);
    do_op(2, 1'b1, 1'b0, 1'b1);
    chk("noise_a5", alu_a, 5);
    chk("noise_b2", alu_b, 2);

    ea = 1'b0;
    tick();
    chk("ea_off", bus_drive, 0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ea = 1'($urandom_range(0, 1));
      load_a(int'($urandom_range(0, M - 1)));
      do_op(int'($urandom_range(0, M - 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand and result stage directly upstream of the 4-bit adder-subtracter in the SAP-1 datapath.
- Holds accumulator A and register B, drives the adder's a/b/SUB inputs, and writes the adder's sum back into A with latched carry and zero flags.
- Loads operands from the shared W-bus and can drive A onto the bus.
- A small FSM sequences ADD/SUB with a start/busy/done handshake; the adder itself stays external.

Parameters:
- WIDTH, 4, datapath width of A, B, bus and adder operands.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- bus_in  input  WIDTH  W-bus value.
- la  input  1  load A from bus_in (IDLE only).
- ea  input  1  enable A onto bus.
- start  input  1  begin ADD/SUB; captures B from bus_in this cycle.
- op_sub  input  1  sampled with start: 1 = SUB, 0 = ADD.
- alu_sum  input  WIDTH  sum from adder-subtracter.
- alu_carry  input  1  carry from adder-subtracter.
- alu_a  output  WIDTH  = A register.
- alu_b  output  WIDTH  = B register.
- alu_sub  output  1  = latched op.
- bus_out  output  WIDTH  = A register.
- bus_drive  output  1  = ea (combinational); owner of tri-state is top level.
- carry_flag  output  1  carry latched at writeback.
- zero_flag  output  1  1 when written-back result == 0.
- busy  output  1  high in SETTLE, WRITE, DONE.
- done  output  1  one-cycle pulse in DONE.

Behaviour:
- Reset (sync, rst=1 at edge): A=0, B=0, op=0, carry_flag=0, zero_flag=0, state=IDLE. Outputs: busy=0, done=0, alu_sub=0. Overrides everything, including mid-operation; the in-flight op is abandoned and A is not written.
- States: IDLE, SETTLE, WRITE, DONE; registered state, one-hot or binary.
- IDLE: if start, then B<=bus_in, op<=op_sub, go to SETTLE. Else if la, then A<=bus_in. start has priority over la in the same cycle (la is dropped).
- SETTLE: one cycle for the adder to settle. A, B and op are held; go to WRITE.
- WRITE: at the edge, A<=alu_sum, carry_flag<=alu_carry, zero_flag<=(alu_sum==0); go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Latency: start sampled at edge 0 → SETTLE in cycle 1 → WRITE cycle 2 (A updated at its end) → done high in cycle 3 → a new start is accepted in cycle 4.
- busy=1 in SETTLE, WRITE and DONE. While busy, start and la are ignored (not queued).
- ea is honoured in every state. bus_out shows the current A, including the new A visible in DONE.
- Arithmetic is modulo 2^WIDTH, with no overflow flag. For SUB, carry_flag=1 means no borrow (A≥B unsigned).
- Flags change only in WRITE. la loads do not affect the flags.

Decomposition:
- Shared package: WIDTH default constant; state encoding constants (IDLE, SETTLE, WRITE, DONE).
- Sub-module: load_register (WIDTH, clk, rst, load, d, q; sync clear), instantiated for A (mux input: bus_in or alu_sum) and for B.
- FSM and flags live in the top of alu_operand_stage.
- Bench instantiates adder_subtracter_4Bit as the alu_* partner.

Test Plan:
- ADD: la with bus=5; start, op_sub=0, bus=3 → done in cycle 3 after start; A=8, carry=0, zero=0; busy high exactly 3 cycles.
- ADD wrap: A=9, B=7 → A=0, carry=1, zero=1.
- SUB: A=5, B=3, op_sub=1 → A=2, carry=1; then A=3, B=5 SUB → A=14 (4'hE), carry=0, zero=0.
- Priority/ignore: la and start in the same IDLE cycle with bus=6 → A unchanged, B=6. start and la pulsed during busy → ignored, A/B unchanged, only one done pulse.
- Reset mid-op: assert rst in the WRITE cycle → next cycle A=0, B=0, flags 0, state IDLE, no done pulse.
- Bus drive: ea=1 in every state → bus_drive=1 and bus_out tracks A, including the new value in DONE.
